// File: rtl/dmem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dmem_pkg
// Brief    : Shared state encoding and access-field constants for the data
//            memory responder and its byte array.
// Revision : 1.0
// ----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam logic RW_READ   = 1'b0;
  localparam logic RW_WRITE  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : dmem_array
// Brief    : Big-endian byte-addressed storage with byte/word read and write
//            muxing. Word accesses always use the aligned base of i_addr.
// Revision : 1.0
// ----------------------------------------------------------------------------
module dmem_array
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [7:0] r_mem [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = {i_addr[ADDR_W-1:2], 2'b00};
  assign w_a1 = {i_addr[ADDR_W-1:2], 2'b01};
  assign w_a2 = {i_addr[ADDR_W-1:2], 2'b10};
  assign w_a3 = {i_addr[ADDR_W-1:2], 2'b11};

  // No reset: contents must survive a responder reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      if (i_size == SIZE_WORD) begin
        r_mem[w_a0] <= i_wdata[31:24];
        r_mem[w_a1] <= i_wdata[23:16];
        r_mem[w_a2] <= i_wdata[15:8];
        r_mem[w_a3] <= i_wdata[7:0];
      end else begin
        r_mem[i_addr] <= i_wdata[7:0];
      end
    end
  end

  always_comb begin
    o_rdata = '0;
    if (i_size == SIZE_WORD) begin
      o_rdata = {r_mem[w_a0], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    end else begin
      o_rdata = {24'b0, r_mem[i_addr]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : data_mem_responder
// Brief    : Wait-stated data memory slave for the MEM stage: IDLE/WAIT/DONE
//            FSM, wait counter, alignment handling. Define
//            DMEM_ALIGN_CHECK_EN to flag misaligned word accesses on err.
// Revision : 1.0
// ----------------------------------------------------------------------------
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              E,
  input  logic              RW,
  input  logic              SIZE,
  input  logic [ADDR_W-1:0] A,
  input  logic [31:0]       DI,
  output logic [31:0]       DO,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] c_cnt_init = 4'(WAIT_CYCLES);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_rw;
  logic              r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_mis;
  logic              r_err;

  logic              w_mis_in;
  logic [ADDR_W-1:0] w_addr_in;
  logic              w_access;
  logic              w_we;
  logic [31:0]       w_rdata;

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_mis_in  = (SIZE == SIZE_WORD) && (A[1:0] != 2'b00);
  assign w_addr_in = A;
  assign err       = r_err;
`else
  assign w_mis_in  = 1'b0;
  assign w_addr_in = (SIZE == SIZE_WORD) ? {A[ADDR_W-1:2], 2'b00} : A;
  assign err       = 1'b0;
`endif

  // The access itself happens on the WAIT->DONE edge.
  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_we     = w_access && (r_rw == RW_WRITE) && !r_mis;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_we),
    .i_size  (r_size),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rw    <= RW_READ;
      r_size  <= SIZE_BYTE;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_mis   <= 1'b0;
      r_err   <= 1'b0;
      DO      <= 32'd0;
      ready   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      ready <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (E) begin
            r_rw    <= RW;
            r_size  <= SIZE;
            r_addr  <= w_addr_in;
            r_wdata <= DI;
            r_mis   <= w_mis_in;
            r_cnt   <= c_cnt_init;
            r_state <= WAIT;
            busy    <= 1'b1;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            ready   <= 1'b1;
            r_err   <= r_mis;
            if ((r_rw == RW_READ) && !r_mis) begin
              DO <= w_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
